// File: rtl/ofmap_write_ctrl.sv
// ofmap_write_ctrl
// ----------------
// Write-side controller for the output feature map of a PE_SIZE-column
// systolic array. Column j of the array delivers its result j cycles after
// column 0. The controller therefore does three things:
//   - it delays the column-0 "row valid" flag through a shift line, which
//     gives one shift enable per lane;
//   - it raises a capture enable once the last lane has its value, so the
//     captured row is aligned;
//   - it issues one sequential memory write per captured row.
// A pass is PE_SIZE*OC rows. It ends after the last row has been written.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start_i      pulse that starts one layer pass (used only in IDLE)
//   row_valid_i  column-0 lane carries a valid result this cycle
//   shift_en_o   per-lane de-skew shift enable (bit j = accepted row delayed j)
//   buff_en_o    aligned-row capture enable
//   mem_addr_o   ofmap memory write address (write counter)
//   mem_ce_o     memory chip enable (always equal to mem_we_o)
//   mem_we_o     memory write enable
//   busy_o       high in every state except IDLE
//   finish_o     one-cycle pulse at the end of a pass
//   err_o        sticky overrun / stray-start flag. This port exists only
//                when the macro OFMAP_WRITE_CTRL_ERR_EN is defined.
//
// Optional feature macro: OFMAP_WRITE_CTRL_ERR_EN
module ofmap_write_ctrl #(
    parameter int PE_SIZE        = 14,
    parameter int OC             = 64,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      row_valid_i,
    output logic [PE_SIZE-1:0]        shift_en_o,
    output logic                      buff_en_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic                      mem_ce_o,
    output logic                      mem_we_o,
    output logic                      busy_o,
    output logic                      finish_o
`ifdef OFMAP_WRITE_CTRL_ERR_EN
    ,
    output logic                      err_o
`endif
);

    localparam int TOTAL = PE_SIZE * OC;
    localparam int CNT_W = $clog2(TOTAL + 1);
    // Shift line bit k holds the accepted flag delayed by k+1 cycles.
    localparam int SH_W  = PE_SIZE - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             accepted_s;
    logic [CNT_W-1:0] row_cnt_r;
    logic [CNT_W-1:0] wr_cnt_r;
    logic [SH_W-1:0]  sh_r;
    logic             we_r;

    // A row counts only while the pass is in RUN; it is ignored in every other state.
    assign accepted_s = row_valid_i & (state_r == RUN);

    assign shift_en_o = {sh_r, accepted_s};
    assign buff_en_o  = sh_r[SH_W-1];
    assign mem_we_o   = we_r;
    assign mem_ce_o   = we_r;
    assign mem_addr_o = MEM_ADDR_WIDTH'(wr_cnt_r);
    assign busy_o     = (state_r != IDLE);
    assign finish_o   = (state_r == DONE);

    // Next-state logic for the pass sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) state_nxt_s = RUN;
                else         state_nxt_s = IDLE;
            end
            RUN: begin
                if (accepted_s && (row_cnt_r == LAST)) state_nxt_s = DRAIN;
                else                                   state_nxt_s = RUN;
            end
            DRAIN: begin
                if (we_r && (wr_cnt_r == LAST)) state_nxt_s = DONE;
                else                            state_nxt_s = DRAIN;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Row counter, de-skew shift line, write strobe and write address.
    // DONE always lasts exactly one cycle, so clearing everything on that
    // cycle leaves the datapath empty whenever the sequencer re-enters IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt_r <= '0;
            wr_cnt_r  <= '0;
            sh_r      <= '0;
            we_r      <= 1'b0;
        end else if (state_r == DONE) begin
            row_cnt_r <= '0;
            wr_cnt_r  <= '0;
            sh_r      <= '0;
            we_r      <= 1'b0;
        end else begin
            if (accepted_s) row_cnt_r <= row_cnt_r + CNT_W'(1);
            // Idle cycles also shift a zero in, so gaps in row_valid_i pass through unchanged.
            sh_r <= SH_W'({sh_r, accepted_s});
            we_r <= sh_r[SH_W-1];
            if (we_r) wr_cnt_r <= wr_cnt_r + CNT_W'(1);
        end
    end

`ifdef OFMAP_WRITE_CTRL_ERR_EN
    logic err_r;
    assign err_o = err_r;

    // Sticky error flag. It is set by a row that arrives after the pass is
    // full, or by a start_i pulse while a pass is running. Only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if ((row_valid_i && ((state_r == DRAIN) || (state_r == DONE))) ||
                     (start_i && ((state_r == RUN) || (state_r == DRAIN)))) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`endif

endmodule
